// File: rtl/amds_packet_rx.sv
// amds_packet_rx: packet sequencer downstream of the AMDS UART byte receiver.
// Arms the receiver once per byte, collects a header plus 2*NUM_CH data bytes
// into a shadow buffer, and commits all samples at once on an error-free packet.
//
// Receiver handshake: start_rx is a one-cycle arm pulse. The receiver clears
// its sticky flags (rx_byte_valid, rx_data_corrupt, rx_timeout) on the edge
// that samples start_rx, then raises exactly one of them and holds it until
// the next arm. Flags are only evaluated in WAIT_BYTE, so they are never stale.
module amds_packet_rx #(
    parameter int         NUM_CH = 8,
    parameter logic [7:0] HEADER = 8'h90
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trigger,
    input  logic                    clear_counters,
    output logic                    start_rx,
    input  logic                    rx_byte_valid,
    input  logic                    rx_data_corrupt,
    input  logic                    rx_timeout,
    input  logic [7:0]              rx_data,
    output logic [16*NUM_CH-1:0]    ch_data,
    output logic                    data_valid,
    output logic                    pkt_done,
    output logic                    busy,
    output logic [15:0]             cnt_corrupt,
    output logic [15:0]             cnt_timeout,
    output logic [15:0]             cnt_bad_header
);

    localparam int NBYTES = 2 * NUM_CH;
    localparam int IW     = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BYTE = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [16*NUM_CH-1:0]   shadow;
    logic [16*NUM_CH-1:0]   shadow_nxt;
    logic [IW-1:0]          byte_sel;

    logic in_wait;
    logic ev_timeout;
    logic ev_corrupt;
    logic ev_valid;
    logic hdr_bad;
    logic last_byte;

    // Flag decode in priority order: timeout > corrupt > valid.
    assign in_wait    = (state == WAIT_BYTE);
    assign ev_timeout = in_wait & rx_timeout;
    assign ev_corrupt = in_wait & ~rx_timeout & rx_data_corrupt;
    assign ev_valid   = in_wait & ~rx_timeout & ~rx_data_corrupt & rx_byte_valid;
    assign hdr_bad    = ev_valid & (idx == '0) & (rx_data != HEADER);
    assign last_byte  = ev_valid & (idx == IW'(NBYTES));

    // Data byte idx (1-based) goes MSB-first per channel: odd idx -> byte 2k+1,
    // even idx -> byte 2k of the flat shadow vector, i.e. (idx-1) with bit 0 flipped.
    assign byte_sel = (idx - IW'(1)) ^ IW'(1);

    // Shadow buffer with the current receive byte merged in at its slot.
    always_comb begin
        shadow_nxt = shadow;
        for (int b = 0; b < NBYTES; b++) begin
            if (byte_sel == IW'(b)) begin
                shadow_nxt[8*b +: 8] = rx_data;
            end
        end
    end

    // Sequencer FSM with registered start_rx/pkt_done/busy and output commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            shadow     <= '0;
            ch_data    <= '0;
            data_valid <= 1'b0;
            start_rx   <= 1'b0;
            pkt_done   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            start_rx <= 1'b0;
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        idx      <= '0;
                        state    <= ISSUE;
                        start_rx <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT_BYTE;
                end
                WAIT_BYTE: begin
                    if (ev_timeout || ev_corrupt || hdr_bad) begin
                        // Abort: outputs untouched, shadow simply gets overwritten later.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (ev_valid) begin
                        if (idx != '0) begin
                            shadow <= shadow_nxt;
                        end
                        idx <= idx + IW'(1);
                        if (last_byte) begin
                            ch_data    <= shadow_nxt;
                            data_valid <= 1'b1;
                            pkt_done   <= 1'b1;
                            state      <= COMMIT;
                        end else begin
                            state    <= ISSUE;
                            start_rx <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating per-class error counters; a same-cycle clear beats an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_corrupt    <= '0;
            cnt_timeout    <= '0;
            cnt_bad_header <= '0;
        end else if (clear_counters) begin
            cnt_corrupt    <= '0;
            cnt_timeout    <= '0;
            cnt_bad_header <= '0;
        end else begin
            if (ev_timeout && (cnt_timeout != 16'hFFFF)) begin
                cnt_timeout <= cnt_timeout + 16'd1;
            end
            if (ev_corrupt && (cnt_corrupt != 16'hFFFF)) begin
                cnt_corrupt <= cnt_corrupt + 16'd1;
            end
            if (hdr_bad && (cnt_bad_header != 16'hFFFF)) begin
                cnt_bad_header <= cnt_bad_header + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_amds_packet_rx.sv
// tb_amds_packet_rx: directed bench for amds_packet_rx with a small receiver
// model that answers each start_rx pulse with one flag.
module tb_amds_packet_rx;

    localparam int NUM_CH = 8;
    localparam int NB     = 2 * NUM_CH + 1;

    // Flag kinds for run_packet
    localparam int K_NONE    = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_CORRUPT = 2;
    localparam int K_RESET   = 3;
    localparam int K_CLR_TO  = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  trigger;
    logic                  clear_counters;
    logic                  start_rx;
    logic                  rx_byte_valid;
    logic                  rx_data_corrupt;
    logic                  rx_timeout;
    logic [7:0]            rx_data;
    logic [16*NUM_CH-1:0]  ch_data;
    logic                  data_valid;
    logic                  pkt_done;
    logic                  busy;
    logic [15:0]           cnt_corrupt;
    logic [15:0]           cnt_timeout;
    logic [15:0]           cnt_bad_header;

    // Hand-written expected sample sets (channel 0 in the low 16 bits)
    logic [127:0] exp_a;
    logic [127:0] exp_b;
    logic [7:0]   pkt_bytes [NB];

    int total;
    int bad;
    int start_cnt;
    int done_cnt;
    int max_wait;

    amds_packet_rx #(.NUM_CH(NUM_CH), .HEADER(8'h90)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .trigger         (trigger),
        .clear_counters  (clear_counters),
        .start_rx        (start_rx),
        .rx_byte_valid   (rx_byte_valid),
        .rx_data_corrupt (rx_data_corrupt),
        .rx_timeout      (rx_timeout),
        .rx_data         (rx_data),
        .ch_data         (ch_data),
        .data_valid      (data_valid),
        .pkt_done        (pkt_done),
        .busy            (busy),
        .cnt_corrupt     (cnt_corrupt),
        .cnt_timeout     (cnt_timeout),
        .cnt_bad_header  (cnt_bad_header)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for arm and commit strobes
    always @(negedge clk) begin
        if (start_rx === 1'b1) start_cnt++;
        if (pkt_done === 1'b1) done_cnt++;
    end

    // Build wire-order bytes: header, then per channel MSB then LSB
    task automatic load_pkt(input logic [127:0] vals, input logic [7:0] hdr);
        pkt_bytes[0] = hdr;
        for (int k = 0; k < NUM_CH; k++) begin
            pkt_bytes[2*k+1] = vals[16*k+8 +: 8];
            pkt_bytes[2*k+2] = vals[16*k   +: 8];
        end
    endtask

    // Trigger, then answer each arm. Returns in the cycle after the last flag.
    task automatic run_packet(input int n_bytes, input int fault_at, input int kind, input bit retrig);
        max_wait = 0;
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0;
        for (int i = 0; i < n_bytes; i++) begin
            int w;
            w = 0;
            while (start_rx !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w > max_wait) max_wait = w;
            total++;
            if (start_rx !== 1'b1) begin
                bad++;
                $display("FAIL arm_wait byte=%0d: start_rx=%b, required 1 within 20 cycles", i, start_rx);
                return;
            end
            // receiver clears its flags on the edge that samples start_rx
            rx_byte_valid   = 1'b0;
            rx_data_corrupt = 1'b0;
            rx_timeout      = 1'b0;
            @(negedge clk);
            if (retrig && i == 3) trigger = 1'b1;
            @(negedge clk);
            trigger = 1'b0;
            if (i == fault_at) begin
                case (kind)
                    K_TIMEOUT: rx_timeout = 1'b1;
                    K_CORRUPT: rx_data_corrupt = 1'b1;
                    K_RESET: begin
                        #1 rst_n = 1'b0;
                        #1;
                        return;
                    end
                    K_CLR_TO: begin
                        rx_timeout     = 1'b1;
                        clear_counters = 1'b1;
                    end
                    default: ;
                endcase
                @(negedge clk);
                clear_counters = 1'b0;
                return;
            end
            rx_data       = pkt_bytes[i];
            rx_byte_valid = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (start_rx !== 1'b0) begin bad++; $display("FAIL reset_start_rx: got %b want 0", start_rx); end
        total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
        total++; if (ch_data !== 128'h0) begin bad++; $display("FAIL reset_ch_data: got %h want 0", ch_data); end
        total++; if ({cnt_corrupt, cnt_timeout, cnt_bad_header} !== 48'h0) begin
            bad++; $display("FAIL reset_counters: got %h/%h/%h want 0/0/0", cnt_corrupt, cnt_timeout, cnt_bad_header);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || start_rx !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: busy=%b start_rx=%b want 0/0", busy, start_rx);
        end
    endtask

    task automatic test_good_packet();
        int s0, d0;
        load_pkt(exp_a, 8'h90);
        s0 = start_cnt; d0 = done_cnt;
        run_packet(NB, -1, K_NONE, 1'b0);
        total++; if (pkt_done !== 1'b1) begin bad++; $display("FAIL good_pkt_done_timing: got %b want 1", pkt_done); end
        total++; if (ch_data !== exp_a) begin bad++; $display("FAIL good_ch_data: got %h want %h", ch_data, exp_a); end
        total++; if (ch_data[15:0] !== 16'h1234 || ch_data[127:112] !== 16'hBEEF) begin
            bad++; $display("FAIL good_ch0_ch7: got %h/%h want 1234/beef", ch_data[15:0], ch_data[127:112]);
        end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL good_data_valid: got %b want 1", data_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL good_busy_commit: got %b want 1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || pkt_done !== 1'b0) begin
            bad++; $display("FAIL good_idle_after_commit: busy=%b pkt_done=%b want 0/0", busy, pkt_done);
        end
        total++; if (start_cnt - s0 != 17) begin bad++; $display("FAIL good_start_count: got %0d want 17", start_cnt - s0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL good_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (max_wait != 0) begin bad++; $display("FAIL good_arm_latency: got %0d extra cycles want 0", max_wait); end
        total++; if ({cnt_corrupt, cnt_timeout, cnt_bad_header} !== 48'h0) begin
            bad++; $display("FAIL good_counters: got %h/%h/%h want 0/0/0", cnt_corrupt, cnt_timeout, cnt_bad_header);
        end
    endtask

    task automatic test_bad_header();
        int s0, d0;
        load_pkt(exp_b, 8'h91);
        s0 = start_cnt; d0 = done_cnt;
        run_packet(1, -1, K_NONE, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hdr_busy: got %b want 0", busy); end
        total++; if (cnt_bad_header !== 16'd1) begin bad++; $display("FAIL hdr_count: got %h want 0001", cnt_bad_header); end
        total++; if (ch_data !== exp_a) begin bad++; $display("FAIL hdr_ch_data_kept: got %h want %h", ch_data, exp_a); end
        repeat (3) @(negedge clk);
        total++; if (done_cnt - d0 != 0 || start_cnt - s0 != 1) begin
            bad++; $display("FAIL hdr_pulses: done=%0d start=%0d want 0/1", done_cnt - d0, start_cnt - s0);
        end
    endtask

    task automatic test_corrupt_then_good();
        int d0;
        load_pkt(exp_b, 8'h90);
        run_packet(NB, 5, K_CORRUPT, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL corrupt_busy: got %b want 0", busy); end
        total++; if (cnt_corrupt !== 16'd1) begin bad++; $display("FAIL corrupt_count: got %h want 0001", cnt_corrupt); end
        total++; if (ch_data !== exp_a) begin bad++; $display("FAIL corrupt_ch_data_kept: got %h want %h", ch_data, exp_a); end
        d0 = done_cnt;
        run_packet(NB, -1, K_NONE, 1'b0);
        @(negedge clk);
        total++; if (ch_data !== exp_b) begin bad++; $display("FAIL second_pkt_ch_data: got %h want %h", ch_data, exp_b); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL second_pkt_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_timeout_and_retrigger();
        int s0, d0;
        load_pkt(exp_a, 8'h90);
        run_packet(NB, 0, K_TIMEOUT, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
        total++; if (cnt_timeout !== 16'd1) begin bad++; $display("FAIL timeout_count: got %h want 0001", cnt_timeout); end
        s0 = start_cnt; d0 = done_cnt;
        run_packet(NB, -1, K_NONE, 1'b1);
        repeat (6) @(negedge clk);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL retrig_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (start_cnt - s0 != 17) begin bad++; $display("FAIL retrig_start_count: got %0d want 17", start_cnt - s0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL retrig_not_queued: busy=%b want 0", busy); end
        total++; if (ch_data !== exp_a) begin bad++; $display("FAIL retrig_ch_data: got %h want %h", ch_data, exp_a); end
    endtask

    task automatic test_saturation_and_clear();
        @(negedge clk);
        force dut.cnt_timeout = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_timeout;
        run_packet(NB, 0, K_TIMEOUT, 1'b0);
        total++; if (cnt_timeout !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %h want ffff", cnt_timeout); end
        run_packet(NB, 0, K_TIMEOUT, 1'b0);
        total++; if (cnt_timeout !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", cnt_timeout); end
        run_packet(NB, 0, K_CLR_TO, 1'b0);
        total++; if ({cnt_corrupt, cnt_timeout, cnt_bad_header} !== 48'h0) begin
            bad++; $display("FAIL clear_wins: got %h/%h/%h want 0/0/0", cnt_corrupt, cnt_timeout, cnt_bad_header);
        end
    endtask

    task automatic test_reset_mid_packet();
        int d0;
        load_pkt(exp_b, 8'h91);
        run_packet(1, -1, K_NONE, 1'b0);
        load_pkt(exp_b, 8'h90);
        run_packet(NB, 9, K_RESET, 1'b0);
        total++; if ({start_rx, pkt_done, busy, data_valid} !== 4'b0000) begin
            bad++; $display("FAIL midrst_flags: start/done/busy/valid=%b want 0000", {start_rx, pkt_done, busy, data_valid});
        end
        total++; if (ch_data !== 128'h0) begin bad++; $display("FAIL midrst_ch_data: got %h want 0", ch_data); end
        total++; if ({cnt_corrupt, cnt_timeout, cnt_bad_header} !== 48'h0) begin
            bad++; $display("FAIL midrst_counters: got %h/%h/%h want 0/0/0", cnt_corrupt, cnt_timeout, cnt_bad_header);
        end
        @(negedge clk);
        rx_byte_valid = 1'b0; rx_data_corrupt = 1'b0; rx_timeout = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        load_pkt(exp_a, 8'h90);
        d0 = done_cnt;
        run_packet(NB, -1, K_NONE, 1'b0);
        @(negedge clk);
        total++; if (ch_data !== exp_a || data_valid !== 1'b1) begin
            bad++; $display("FAIL post_rst_pkt: ch_data=%h valid=%b want %h/1", ch_data, data_valid, exp_a);
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL post_rst_done: got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        total = 0; bad = 0; start_cnt = 0; done_cnt = 0; max_wait = 0;
        exp_a = 128'hBEEF_ACE0_2468_1357_DEF0_9ABC_5678_1234;
        exp_b = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
        trigger = 1'b0; clear_counters = 1'b0;
        rx_byte_valid = 1'b0; rx_data_corrupt = 1'b0; rx_timeout = 1'b0; rx_data = 8'h00;
        rst_n = 1'b0;
        test_reset();
        test_good_packet();
        test_bad_header();
        test_corrupt_then_good();
        test_timeout_and_retrigger();
        test_saturation_and_clear();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
